// File: rtl/i2c_status_pkg.sv
// ============================================================================
// Module : i2c_status_pkg
// Brief  : Shared constants for the Status CPLD I2C target: FSM state
//          encoding, default device address, ACK/NACK levels, RD_WR
//          polarity, read-access length and the one-hot decode helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_status_pkg;

    // FSM state encoding
    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_DEVADDR = 4'd1;
    localparam logic [3:0] c_ST_DEV_ACK = 4'd2;
    localparam logic [3:0] c_ST_REGADDR = 4'd3;
    localparam logic [3:0] c_ST_REG_ACK = 4'd4;
    localparam logic [3:0] c_ST_WDATA   = 4'd5;
    localparam logic [3:0] c_ST_W_ACK   = 4'd6;
    localparam logic [3:0] c_ST_RFETCH  = 4'd7;
    localparam logic [3:0] c_ST_RSHIFT  = 4'd8;
    localparam logic [3:0] c_ST_R_MACK  = 4'd9;

    // Default 7-bit target address
    localparam logic [6:0] c_DEV_ADDR_DEFAULT = 7'h3C;

    // SDA levels during the acknowledge bit
    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

    // RD_WR polarity
    localparam logic c_RDWR_READ  = 1'b1;
    localparam logic c_RDWR_WRITE = 1'b0;

    // Read strobe length in SYSCLK cycles; RDATA is captured on the cycle after
    localparam logic [1:0] c_RD_ACCESS_CYCLES = 2'd2;

    // 4-bit index to 16-bit one-hot select
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// Module : i2c_line_filter
// Brief  : Two-flop synchroniser for one I2C line, optional 3-sample majority
//          filter (macro I2C_GLITCH_FILTER_EN), level and rise/fall pulses.
//          Latency pin->edge: 2 cycles, 4 cycles with the filter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_line_filter (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       w_level;

    // Two-flop synchroniser; idle bus level is high
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], line_i};
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    // Three-sample history; a 1-cycle pulse can never win the majority vote
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) hist_q <= 3'b111;
        else          hist_q <= {hist_q[1:0], sync_q[1]};
    end

    assign w_level = (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) |
                     (hist_q[0] & hist_q[2]);
`else
    assign w_level = sync_q[1];
`endif

    // Previous filtered level for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) prev_q <= 1'b1;
        else          prev_q <= w_level;
    end

    assign level_o = w_level;
    assign rise_o  = w_level & ~prev_q;
    assign fall_o  = ~w_level & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_status_slave.sv
// ============================================================================
// Module : i2c_status_slave
// Brief  : I2C target front-end for the Status CPLD register space. Decodes
//          START/STOP, device address, register pointer and data bytes and
//          turns each byte access into a one-hot PORT_CS/OFFSET_SEL strobe.
//          Optional SCL/SDA majority glitch filter: I2C_GLITCH_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_status_slave
    import i2c_status_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = c_DEV_ADDR_DEFAULT
) (
    input  logic        SYSCLK,
    input  logic        RESET_N,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic [15:0] PORT_CS,
    output logic [15:0] OFFSET_SEL,
    output logic        RD_WR,
    output logic [7:0]  DOUT,
    input  logic [7:0]  RDATA,
    output logic        BUSY
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_ptr_inc;

    logic [3:0]  state_q,      state_d;
    logic [3:0]  bitcnt_q,     bitcnt_d;
    logic [7:0]  shift_q,      shift_d;
    logic [7:0]  ptr_q,        ptr_d;
    logic        sda_oe_q,     sda_oe_d;
    logic        busy_q,       busy_d;
    logic [15:0] port_cs_q,    port_cs_d;
    logic [15:0] offset_sel_q, offset_sel_d;
    logic        rd_wr_q,      rd_wr_d;
    logic [7:0]  dout_q,       dout_d;
    logic [1:0]  rd_cnt_q,     rd_cnt_d;

    i2c_line_filter u_scl_filt (
        .clk_i   (SYSCLK),
        .rst_n_i (RESET_N),
        .line_i  (SCL_IN),
        .level_o (w_scl),
        .rise_o  (w_scl_rise),
        .fall_o  (w_scl_fall)
    );

    i2c_line_filter u_sda_filt (
        .clk_i   (SYSCLK),
        .rst_n_i (RESET_N),
        .line_i  (SDA_IN),
        .level_o (w_sda),
        .rise_o  (w_sda_rise),
        .fall_o  (w_sda_fall)
    );

    assign w_start   = w_sda_fall & w_scl;
    assign w_stop    = w_sda_rise & w_scl;
    assign w_ptr_inc = ptr_q + 8'd1;

    // Protocol FSM: bit shifting, ACK drive, pointer update and strobe generation
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        port_cs_d    = 16'h0000;
        offset_sel_d = 16'h0000;
        rd_wr_d      = c_RDWR_READ;
        dout_d       = dout_q;
        rd_cnt_d     = rd_cnt_q;

        if (w_stop) begin
            state_d  = c_ST_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
        end else if (w_start) begin
            state_d  = c_ST_DEVADDR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                c_ST_DEVADDR, c_ST_REGADDR, c_ST_WDATA: begin
                    if (w_scl_rise && bitcnt_q != 4'd8) begin
                        shift_d  = {shift_q[6:0], w_sda};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (w_scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == c_ST_DEVADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                sda_oe_d = ~c_ACK;
                                busy_d   = 1'b1;
                                state_d  = c_ST_DEV_ACK;
                            end else begin
                                state_d  = c_ST_IDLE;
                            end
                        end else if (state_q == c_ST_REGADDR) begin
                            ptr_d    = shift_q;
                            sda_oe_d = ~c_ACK;
                            state_d  = c_ST_REG_ACK;
                        end else begin
                            port_cs_d    = onehot16(ptr_q[7:4]);
                            offset_sel_d = onehot16(ptr_q[3:0]);
                            rd_wr_d      = c_RDWR_WRITE;
                            dout_d       = shift_q;
                            ptr_d        = w_ptr_inc;
                            sda_oe_d     = ~c_ACK;
                            state_d      = c_ST_W_ACK;
                        end
                    end
                end

                c_ST_DEV_ACK: begin
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        if (shift_q[0] == c_RDWR_READ) begin
                            port_cs_d    = onehot16(ptr_q[7:4]);
                            offset_sel_d = onehot16(ptr_q[3:0]);
                            rd_cnt_d     = 2'd0;
                            state_d      = c_ST_RFETCH;
                        end else begin
                            state_d      = c_ST_REGADDR;
                        end
                    end
                end

                c_ST_REG_ACK, c_ST_W_ACK: begin
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = c_ST_WDATA;
                    end
                end

                c_ST_RFETCH: begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                    if (rd_cnt_q < c_RD_ACCESS_CYCLES - 2'd1) begin
                        port_cs_d    = port_cs_q;
                        offset_sel_d = offset_sel_q;
                    end
                    if (rd_cnt_q == c_RD_ACCESS_CYCLES) begin
                        state_d = c_ST_RSHIFT;
                        // Drive MSB now only if SCL is low; otherwise wait for the fall
                        if (!w_scl) begin
                            sda_oe_d = ~RDATA[7];
                            shift_d  = {RDATA[6:0], 1'b0};
                            bitcnt_d = 4'd1;
                        end else begin
                            shift_d  = RDATA;
                            bitcnt_d = 4'd0;
                        end
                    end
                end

                c_ST_RSHIFT: begin
                    if (w_scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = c_ST_R_MACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end

                c_ST_R_MACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == c_ACK) begin
                            ptr_d        = w_ptr_inc;
                            port_cs_d    = onehot16(w_ptr_inc[7:4]);
                            offset_sel_d = onehot16(w_ptr_inc[3:0]);
                            rd_cnt_d     = 2'd0;
                            state_d      = c_ST_RFETCH;
                        end else begin
                            state_d      = c_ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = c_ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            state_q      <= c_ST_IDLE;
            bitcnt_q     <= 4'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 8'h00;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            port_cs_q    <= 16'h0000;
            offset_sel_q <= 16'h0000;
            rd_wr_q      <= c_RDWR_READ;
            dout_q       <= 8'h00;
            rd_cnt_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            port_cs_q    <= port_cs_d;
            offset_sel_q <= offset_sel_d;
            rd_wr_q      <= rd_wr_d;
            dout_q       <= dout_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign SDA_OE     = sda_oe_q;
    assign PORT_CS    = port_cs_q;
    assign OFFSET_SEL = offset_sel_q;
    assign RD_WR      = rd_wr_q;
    assign DOUT       = dout_q;
    assign BUSY       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_status_slave.sv
// ============================================================================
// Module : tb_i2c_status_slave
// Brief  : Self-checking bench for i2c_status_slave: bit-level I2C master,
//          register-space model, strobe scoreboard, directed and random
//          transactions. Glitch case runs when I2C_GLITCH_FILTER_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_status_slave;

    localparam int QT = 100;               // quarter of an SCL bit = 10 SYSCLK
    localparam logic [6:0] ADDR = 7'h3C;

    logic        SYSCLK  = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SCL_IN  = 1'b1;
    logic        sda_m   = 1'b1;
    logic        SDA_IN;
    logic        SDA_OE;
    logic [15:0] PORT_CS;
    logic [15:0] OFFSET_SEL;
    logic        RD_WR;
    logic [7:0]  DOUT;
    logic [7:0]  RDATA = 8'h00;
    logic        BUSY;

    int n_cmp = 0;
    int n_err = 0;

    assign SDA_IN = sda_m & ~SDA_OE;

    always #5 SYSCLK = ~SYSCLK;

    i2c_status_slave #(.DEV_ADDR(ADDR)) dut (
        .SYSCLK     (SYSCLK),
        .RESET_N    (RESET_N),
        .SCL_IN     (SCL_IN),
        .SDA_IN     (SDA_IN),
        .SDA_OE     (SDA_OE),
        .PORT_CS    (PORT_CS),
        .OFFSET_SEL (OFFSET_SEL),
        .RD_WR      (RD_WR),
        .DOUT       (DOUT),
        .RDATA      (RDATA),
        .BUSY       (BUSY)
    );

    // Port register blocks (driven by DUT strobes) and the bench's reference copy
    logic [7:0] port_mem [256];
    logic [7:0] ref_mem  [256];
    logic [7:0] ref_ptr = 8'h00;
    logic [7:0] wbuf [4];

    typedef struct packed {
        logic       rd;
        logic [7:0] ptr;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    function automatic int oh_idx(input logic [15:0] v);
        int n = 0;
        int r = -1;
        for (int i = 0; i < 16; i++) if (v[i]) begin n++; r = i; end
        return (n == 1) ? r : -1;
    endfunction

    // Registered port blocks: strobed register drives RDATA the cycle after
    always @(posedge SYSCLK) begin
        int pi;
        int oi;
        pi = oh_idx(PORT_CS);
        oi = oh_idx(OFFSET_SEL);
        RDATA <= 8'h00;
        if (pi >= 0 && oi >= 0) begin
            if (RD_WR) RDATA <= port_mem[pi*16 + oi];
            else       port_mem[pi*16 + oi] <= DOUT;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Strobe monitor: collects each strobe and compares it with the queue head
    logic        m_act = 1'b0;
    logic [15:0] m_cs, m_os;
    logic        m_rw;
    logic [7:0]  m_dout;
    int          m_len = 0;

    always @(negedge SYSCLK) begin
        logic now_act;
        exp_t e;
        now_act = (PORT_CS != 16'h0) || (OFFSET_SEL != 16'h0) || (RD_WR == 1'b0);
        if (now_act && m_act && PORT_CS == m_cs && OFFSET_SEL == m_os &&
            RD_WR == m_rw && DOUT == m_dout) begin
            m_len++;
        end else begin
            if (m_act) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe_unexpected: got cs=%h os=%h rdwr=%b dout=%h len=%0d, required no strobe",
                             m_cs, m_os, m_rw, m_dout, m_len);
                end else begin
                    e = exp_q.pop_front();
                    if (m_cs !== (16'h1 << e.ptr[7:4]) || m_os !== (16'h1 << e.ptr[3:0]) ||
                        m_rw !== e.rd || m_len != (e.rd ? 2 : 1) || (!e.rd && m_dout !== e.data)) begin
                        n_err++;
                        $display("FAIL strobe: got cs=%h os=%h rdwr=%b dout=%h len=%0d, required cs=%h os=%h rdwr=%b dout=%h len=%0d",
                                 m_cs, m_os, m_rw, m_dout, m_len,
                                 16'h1 << e.ptr[7:4], 16'h1 << e.ptr[3:0], e.rd, e.data, e.rd ? 2 : 1);
                    end
                end
            end
            m_act = now_act;
            if (now_act) begin
                m_cs   = PORT_CS;
                m_os   = OFFSET_SEL;
                m_rw   = RD_WR;
                m_dout = DOUT;
                m_len  = 1;
            end
        end
    end

    // ---------------- bit-level I2C master ----------------
    task automatic clk_bit(input logic d, output logic s);
        sda_m = d; #(QT);
        SCL_IN = 1'b1; #(QT);
        s = SDA_IN; #(QT);
        SCL_IN = 1'b0; #(QT);
    endtask

    // Same bit with a 1-SYSCLK SCL pulse inside the low phase
    task automatic clk_bit_glitch(input logic d, output logic s);
        sda_m = d; #(QT/2);
        SCL_IN = 1'b1; #10;
        SCL_IN = 1'b0; #(QT/2 - 10);
        SCL_IN = 1'b1; #(QT);
        s = SDA_IN; #(QT);
        SCL_IN = 1'b0; #(QT);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #(QT);
        SCL_IN = 1'b1; #(QT);
        sda_m = 1'b0; #(QT);
        SCL_IN = 1'b0; #(QT);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(QT);
        SCL_IN = 1'b1; #(QT);
        sda_m = 1'b1; #(QT);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            if (glitch && i == 4) clk_bit_glitch(b[i], s);
            else                  clk_bit(b[i], s);
        end
        clk_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, b[i]);
        clk_bit(mack ? 1'b0 : 1'b1, s);
    endtask

    // ---------------- transaction level ----------------
    task automatic do_write(input logic [7:0] ptr, input int n, input logic glitch);
        logic a;
        i2c_start();
        write_byte({ADDR, 1'b0}, 1'b0, a);
        chk("w_addr_ack", a, 1);
        chk("w_busy", BUSY, 1);
        write_byte(ptr, 1'b0, a);
        chk("w_ptr_ack", a, 1);
        ref_ptr = ptr;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{rd: 1'b0, ptr: ref_ptr, data: wbuf[k]});
            ref_mem[ref_ptr] = wbuf[k];
            write_byte(wbuf[k], glitch && k == 0, a);
            chk("w_data_ack", a, 1);
            ref_ptr = ref_ptr + 8'd1;
        end
        i2c_stop();
        chk("w_busy_after_stop", BUSY, 0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
        logic a;
        logic [7:0] b;
        if (set_ptr) begin
            i2c_start();
            write_byte({ADDR, 1'b0}, 1'b0, a);
            chk("r_waddr_ack", a, 1);
            write_byte(ptr, 1'b0, a);
            chk("r_ptr_ack", a, 1);
            ref_ptr = ptr;
        end
        for (int k = 0; k < n; k++)
            exp_q.push_back('{rd: 1'b1, ptr: ref_ptr + 8'(k), data: 8'h00});
        i2c_start();
        write_byte({ADDR, 1'b1}, 1'b0, a);
        chk("r_addr_ack", a, 1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, b);
            chk("r_data", b, ref_mem[ref_ptr]);
            if (k < n - 1) ref_ptr = ref_ptr + 8'd1;
        end
        i2c_stop();
        chk("r_busy_after_stop", BUSY, 0);
    endtask

    // Watchdog
    initial begin
        #(900_000);
        n_err++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic a;
        logic s;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            port_mem[i] = b;
            ref_mem[i]  = b;
        end
        port_mem[0] = 8'h5A; ref_mem[0] = 8'h5A;
        port_mem[1] = 8'h01; ref_mem[1] = 8'h01;

        // Reset state
        #100;
        chk("rst_sda_oe",  SDA_OE, 0);
        chk("rst_port_cs", PORT_CS, 0);
        chk("rst_offset",  OFFSET_SEL, 0);
        chk("rst_rd_wr",   RD_WR, 1);
        chk("rst_dout",    DOUT, 0);
        chk("rst_busy",    BUSY, 0);
        RESET_N = 1'b1;
        #(4*QT);

        // Single write 8'h12 = 8'hA5
        wbuf[0] = 8'hA5;
        do_write(8'h12, 1, 1'b0);

        // Pointer 0, repeated START, read two bytes
        do_read(1'b1, 8'h00, 2);

        // Address mismatch: no ACK, no strobes
        i2c_start();
        write_byte({7'h3D, 1'b0}, 1'b0, a);
        chk("mismatch_nack", a, 0);
        chk("mismatch_busy", BUSY, 0);
        write_byte(8'h12, 1'b0, a);
        chk("mismatch_ignored", a, 0);
        i2c_stop();
        wbuf[0] = 8'h3C;
        do_write(8'h20, 1, 1'b0);

        // Burst write across pointer wrap
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'hFF, 2, 1'b0);

        // Reset during the 4th data bit of a read
        do_read(1'b1, 8'h40, 1);
        exp_q.push_back('{rd: 1'b1, ptr: ref_ptr, data: 8'h00});
        i2c_start();
        write_byte({ADDR, 1'b1}, 1'b0, a);
        chk("rst_rd_addr_ack", a, 1);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        sda_m = 1'b1; #(QT);
        SCL_IN = 1'b1; #(QT/2);
        RESET_N = 1'b0; #10;
        chk("midrst_sda_oe",  SDA_OE, 0);
        chk("midrst_port_cs", PORT_CS, 0);
        chk("midrst_busy",    BUSY, 0);
        RESET_N = 1'b1;
        ref_ptr = 8'h00;
        #(QT/2 - 10);
        SCL_IN = 1'b0; #(QT);
        i2c_stop();
        do_read(1'b0, 8'h00, 1);

`ifdef I2C_GLITCH_FILTER_EN
        wbuf[0] = 8'hC3;
        do_write(8'h33, 1, 1'b1);
        do_read(1'b1, 8'h33, 1);
`endif

        // Random transactions
        for (int t = 0; t < 12; t++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            if (kind == 0) begin
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                do_write(8'($urandom), n, 1'b0);
            end else if (kind == 1) begin
                do_read(1'b1, 8'($urandom), n);
            end else begin
                do_read(1'b0, 8'h00, n);
            end
        end

        #(4*QT);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_status_slave.md
# i2c_status_slave

I2C target front-end for the Status CPLD register space. It synchronises SCL/SDA, decodes START/STOP, device address, register pointer and data bytes, and converts each byte access into a one-hot port/offset register strobe consumed by the per-port register blocks (HEADER and its peers). Read data returned by those blocks on a shared 8-bit bus is shifted back onto SDA.

## Interface
Parameters:
- DEV_ADDR, 7'h3C: 7-bit I2C target address.

Ports:
- SYSCLK  in  1: system clock. One clock; reset is synchronous and active-low.
- RESET_N  in  1: synchronous, active-low reset.
- SCL_IN  in  1: raw SCL pin level.
- SDA_IN  in  1: raw SDA pin level.
- SDA_OE  out  1: 1 = pull SDA low (open-drain).
- PORT_CS  out  16: one-hot port select, decoded from reg_ptr[7:4].
- OFFSET_SEL  out  16: one-hot offset select, decoded from reg_ptr[3:0].
- RD_WR  out  1: 1 = read, 0 = write.
- DOUT  out  8: write data, drives the ports' DIN.
- RDATA  in  8: OR of all port DOUT buses.
- BUSY  out  1: high from an addressed START until STOP.

## Operation
- Line front-end: 2-flop synchroniser on SCL/SDA, then edge detect.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- States:
  - IDLE
  - DEVADDR: shift 8 bits on SCL rise.
  - DEV_ACK
  - REGADDR
  - REG_ACK
  - WDATA
  - W_ACK
  - RFETCH
  - RSHIFT
  - R_MACK
- START from any state goes to DEVADDR with bit count 0.
- STOP from any state goes to IDLE and clears BUSY.
- DEVADDR, address match:
  - R/W=0: ACK, then REGADDR.
  - R/W=1: ACK, then RFETCH.
- DEVADDR, mismatch: no ACK, go to IDLE and ignore the bus until the next START.
- REGADDR: load reg_ptr after 8 bits, ACK, then WDATA.
- WDATA: after 8 bits, commit the write, ACK, increment reg_ptr.
- RFETCH: read access at reg_ptr, load the shift register, go to RSHIFT.
- RSHIFT: drive bits MSB first; SDA_OE = ~bit.
- R_MACK, on the master-ack SCL rise:
  - ACK: increment reg_ptr, go to RFETCH.
  - NACK: go to IDLE (waiting for STOP).
- reg_ptr is 8 bits and wraps 8'hFF→8'h00. It persists across repeated START and STOP. Reset clears it to 0.
- Write commit: a single SYSCLK cycle with PORT_CS/OFFSET_SEL = decode(reg_ptr), RD_WR=0 and DOUT = data byte.
- Read access: PORT_CS/OFFSET_SEL = decode(reg_ptr) and RD_WR=1, held for exactly 2 cycles. RDATA is captured on the 3rd cycle, because port DOUT is registered.
- Outside strobes: PORT_CS=0, OFFSET_SEL=0, RD_WR=1. DOUT holds its last value.
- Reset (also mid-transfer), all synchronous on the next SYSCLK edge:
  - SDA_OE=0, PORT_CS=0, OFFSET_SEL=0, RD_WR=1, DOUT=0, BUSY=0.
  - State = IDLE, reg_ptr=0.

## Timing
- SYSCLK ≥ 16× SCL frequency is required.
- Input latency: 2 cycles from pin to detected edge; +2 with the filter enabled.
- SDA_OE changes only 1 SYSCLK after a detected SCL fall. It is never changed while SCL is high.
- ACK: SDA_OE=1 from the SCL fall after bit 8 until the following SCL fall.
- Write commit fires 1 cycle after the SCL fall that ends the 8th data bit.
- Read access starts:
  - 1 cycle after the SCL fall that ends DEV_ACK, or
  - 1 cycle after the master-ACK SCL rise.
- The first data bit is driven within 5 cycles of read access start.
- START or STOP during a read access aborts it: strobes are deasserted next cycle.

## Configuration
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchroniser on each line; pulses ≤1 SYSCLK are rejected; input latency is 4 cycles.
- Undefined: synchroniser only; latency is 2 cycles.

## Structure
- Shared status package holds:
  - the state encoding;
  - the default DEV_ADDR;
  - the ACK/NACK constants;
  - the RD_WR polarity constants;
  - the 2-cycle read-access length.
- Sub-module i2c_line_filter, one instance per line:
  - synchroniser plus optional majority filter;
  - rise/fall outputs.

## Test plan
- Write addr 8'h12 = 8'hA5 → one cycle with PORT_CS=16'h0002, OFFSET_SEL=16'h0004, RD_WR=0, DOUT=8'hA5; ACK after both bytes.
- Write ptr 8'h00, repeated START, read 2 bytes, master NACK on the 2nd (RDATA model: ptr 0→8'h5A, 1→8'h01).
  - Read accesses at OFFSET_SEL=16'h0001, then 16'h0002; each strobe lasts 2 cycles.
  - SDA carries 8'h5A then 8'h01.
- Address 7'h3D with DEV_ADDR 7'h3C → no ACK, no strobes; the next START to 7'h3C is served normally.
- Burst write starting at ptr 8'hFF, 2 data bytes → commits at 8'hFF (PORT_CS=16'h8000, OFFSET_SEL=16'h8000), then 8'h00.
- RESET_N low during the 4th data bit of a read → next cycle SDA_OE=0, PORT_CS=0, BUSY=0; the next read returns data from ptr 8'h00.
- I2C_GLITCH_FILTER_EN defined, 1-cycle SCL glitch mid-byte → bit count unchanged and the byte is received correctly.
